// File: rtl/uart_tx_arbiter_if.sv
// Request/transmitter bundle for uart_tx_arbiter: the arbiter takes the master
// modport, the request sources and transmitter together sit on the slave side.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int DATA_W  = 8
);
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        gnt;
  logic [NUM_REQ-1:0]        done;
  logic [DATA_W-1:0]         tx_data;
  logic                      tx_start;
  logic                      tx_busy;
  logic                      arb_idle;
  logic                      err;

  modport master (
    input  req, req_data, tx_busy,
    output gnt, done, tx_data, tx_start, arb_idle, err
  );

  modport slave (
    output req, req_data, tx_busy,
    input  gnt, done, tx_data, tx_start, arb_idle, err
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART byte transmitter among NUM_REQ requesters.
// Optional busy-acknowledge timeout enabled by defining UART_TX_ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int DATA_W  = 8
`ifdef UART_TX_ARB_TIMEOUT_EN
  ,
  parameter int ACK_TIMEOUT = 16
`endif
) (
  input  logic                clk,
  input  logic                reset,
  uart_tx_arbiter_if.master   bus
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {IDLE, START, WAIT_BUSY, WAIT_DONE} state_t;

  state_t              state_r, state_s;
  logic [NUM_REQ-1:0]  gnt_r, gnt_s;
  logic [NUM_REQ-1:0]  done_r, done_s;
  logic [DATA_W-1:0]   tx_data_r, tx_data_s;
  logic                tx_start_r, tx_start_s;
  logic                arb_idle_r, arb_idle_s;
  logic                err_r, err_s;
  logic [IDX_W-1:0]    last_r, last_s;
  logic [IDX_W-1:0]    win_r, win_s;
  logic [IDX_W-1:0]    pick_s;

`ifdef UART_TX_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);
  logic [CNT_W-1:0]    cnt_r, cnt_s;
`endif

  // Scan requesters starting just after the last winner, wrapping at NUM_REQ.
  function automatic logic [IDX_W-1:0] pick(input logic [NUM_REQ-1:0] r,
                                            input logic [IDX_W-1:0]   last);
    int unsigned idx;
    logic        found;
    logic [IDX_W-1:0] win;
    found = 1'b0;
    win   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = int'(last) + k;
      if (idx >= NUM_REQ) begin
        idx = idx - NUM_REQ;
      end else begin
        idx = idx;
      end
      if (!found && r[idx[IDX_W-1:0]]) begin
        found = 1'b1;
        win   = idx[IDX_W-1:0];
      end else begin
        found = found;
      end
    end
    return win;
  endfunction

  // Next-state and next-output computation for the transfer sequencer.
  always_comb begin
    state_s    = state_r;
    gnt_s      = gnt_r;
    done_s     = '0;
    tx_data_s  = tx_data_r;
    tx_start_s = 1'b0;
    err_s      = 1'b0;
    last_s     = last_r;
    win_s      = win_r;
`ifdef UART_TX_ARB_TIMEOUT_EN
    cnt_s      = '0;
`endif
    pick_s     = pick(bus.req, last_r);
    case (state_r)
      IDLE: begin
        if ((|bus.req) && !bus.tx_busy) begin
          state_s         = START;
          win_s           = pick_s;
          gnt_s           = '0;
          gnt_s[pick_s]   = 1'b1;
          tx_data_s       = bus.req_data[int'(pick_s)*DATA_W +: DATA_W];
          tx_start_s      = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      START: begin
        state_s = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (bus.tx_busy) begin
          state_s = WAIT_DONE;
        end else begin
`ifdef UART_TX_ARB_TIMEOUT_EN
          // Transmitter never acknowledged: abort as a completed-with-error transfer.
          if (cnt_r == CNT_W'(ACK_TIMEOUT - 1)) begin
            state_s = IDLE;
            done_s  = gnt_r;
            err_s   = 1'b1;
            gnt_s   = '0;
            last_s  = win_r;
          end else begin
            cnt_s = cnt_r + CNT_W'(1);
          end
`else
          state_s = WAIT_BUSY;
`endif
        end
      end
      WAIT_DONE: begin
        if (!bus.tx_busy) begin
          state_s = IDLE;
          done_s  = gnt_r;
          gnt_s   = '0;
          last_s  = win_r;
        end else begin
          state_s = WAIT_DONE;
        end
      end
      default: begin
        state_s = IDLE;
        gnt_s   = '0;
      end
    endcase
    arb_idle_s = (state_s == IDLE);
  end

  // State, pointer and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= IDLE;
      gnt_r      <= '0;
      done_r     <= '0;
      tx_data_r  <= '0;
      tx_start_r <= 1'b0;
      arb_idle_r <= 1'b1;
      err_r      <= 1'b0;
      last_r     <= IDX_W'(NUM_REQ - 1);
      win_r      <= '0;
`ifdef UART_TX_ARB_TIMEOUT_EN
      cnt_r      <= '0;
`endif
    end else begin
      state_r    <= state_s;
      gnt_r      <= gnt_s;
      done_r     <= done_s;
      tx_data_r  <= tx_data_s;
      tx_start_r <= tx_start_s;
      arb_idle_r <= arb_idle_s;
      err_r      <= err_s;
      last_r     <= last_s;
      win_r      <= win_s;
`ifdef UART_TX_ARB_TIMEOUT_EN
      cnt_r      <= cnt_s;
`endif
    end
  end

  assign bus.gnt      = gnt_r;
  assign bus.done     = done_r;
  assign bus.tx_data  = tx_data_r;
  assign bus.tx_start = tx_start_r;
  assign bus.arb_idle = arb_idle_r;
  assign bus.err      = err_r;

endmodule
